// File: rtl/switch_sched_pkg.sv
// Shared types and constants for the 4-port crossbar burst scheduler.
package switch_sched_pkg;

  localparam int NUM_PORTS    = 4;
  localparam int SEL_W        = $clog2(NUM_PORTS);
  localparam int LEN_W        = 4;
  localparam int STARVE_LIMIT = 15;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [LEN_W-1:0]     burst_len_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

endpackage

// File: rtl/switch_sched_rr_alloc.sv
// Combinational masked round-robin allocator: all-or-nothing multicast grants,
// priority inputs scanned first with their outputs reserved against later inputs.
module switch_sched_rr_alloc
  import switch_sched_pkg::*;
(
  input  logic [NUM_PORTS-1:0]           i_req,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] i_masks,
  input  logic [NUM_PORTS-1:0]           i_free,
  input  logic [NUM_PORTS-1:0]           i_prio,
  input  logic [SEL_W-1:0]               i_ptr,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic [SEL_W-1:0]               o_next_ptr
);

  port_mask_t w_avail;
  port_mask_t w_mask;
  logic       w_found;
  int         w_idx;

  always_comb begin
    w_avail    = i_free;
    w_mask     = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    o_grant    = '0;
    o_next_ptr = i_ptr;
    // Pass 0 scans starved inputs, pass 1 the rest; a starved loser still holds its outputs.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_idx = (int'(i_ptr) + k) % NUM_PORTS;
        if (i_req[w_idx] && (i_prio[w_idx] == (pass == 0))) begin
          w_mask = i_masks[w_idx*NUM_PORTS +: NUM_PORTS];
          if ((w_mask & ~w_avail) == '0) begin
            o_grant[w_idx] = 1'b1;
            w_avail        = w_avail & ~w_mask;
          end else if (pass == 0) begin
            w_avail = w_avail & ~w_mask;
          end
        end
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_PORTS;
      if (!w_found && o_grant[w_idx]) begin
        w_found    = 1'b1;
        o_next_ptr = SEL_W'((w_idx + 1) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/switch_sched.sv
// Burst-level crossbar scheduler: holds input->output connections for whole packets.
// Optional starvation guard enabled by defining SCHED_STARVE_GUARD_EN.
module switch_sched
  import switch_sched_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] i_req_dst,
  input  logic [NUM_PORTS*LEN_W-1:0]     i_req_len,
  input  logic [NUM_PORTS-1:0]           i_out_ready,
  output logic [NUM_PORTS-1:0]           o_pop,
  output logic [NUM_PORTS*SEL_W-1:0]     o_mux_sel,
  output logic [NUM_PORTS-1:0]           o_active,
  output logic [NUM_PORTS-1:0]           o_busy
);

  sched_state_e                 r_state     [NUM_PORTS];
  sched_state_e                 w_state_nxt [NUM_PORTS];
  burst_len_t                   r_cnt       [NUM_PORTS];
  port_mask_t                   r_dst       [NUM_PORTS];
  port_mask_t                   r_active, w_active_nxt;
  logic [NUM_PORTS*SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]             r_ptr, w_ptr_nxt;
  port_mask_t                   w_req, w_grant, w_pop, w_last, w_prio;

  always_comb begin
    w_req  = '0;
    w_pop  = '0;
    w_last = '0;
    o_busy = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req[i]  = (r_state[i] == IDLE) && (i_req_dst[i*NUM_PORTS +: NUM_PORTS] != '0);
      // A multicast beat moves only when every latched destination is ready.
      w_pop[i]  = (r_state[i] == XFER) && ((r_dst[i] & ~i_out_ready) == '0);
      w_last[i] = w_pop[i] && (r_cnt[i] == '0);
      o_busy[i] = (r_state[i] == XFER);
    end
  end

  switch_sched_rr_alloc u_alloc (
    .i_req      (w_req),
    .i_masks    (i_req_dst),
    .i_free     (~r_active),
    .i_prio     (w_prio),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_ptr_nxt)
  );

`ifdef SCHED_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  logic [WAIT_W-1:0] r_wait [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_grant[i])
          r_wait[i] <= '0;
        else if (w_req[i] && (r_wait[i] != WAIT_W'(STARVE_LIMIT)))
          r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_prio = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_prio[i] = (r_wait[i] == WAIT_W'(STARVE_LIMIT));
  end
`else
  assign w_prio = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        IDLE:    if (w_grant[i]) w_state_nxt[i] = XFER;
        XFER:    if (w_last[i])  w_state_nxt[i] = IDLE;
        default: w_state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Releases and grants never touch the same output in one cycle: grants need free outputs.
  always_comb begin
    w_active_nxt = r_active;
    w_sel_nxt    = r_sel;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_last[i]) w_active_nxt = w_active_nxt & ~r_dst[i];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_grant[i] && i_req_dst[i*NUM_PORTS + o]) begin
          w_active_nxt[o]                = 1'b1;
          w_sel_nxt[o*SEL_W +: SEL_W]    = SEL_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
      r_sel    <= '0;
      r_ptr    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_cnt[i] <= '0;
        r_dst[i] <= '0;
      end
    end else begin
      r_active <= w_active_nxt;
      r_sel    <= w_sel_nxt;
      if (w_grant != '0) r_ptr <= w_ptr_nxt;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_grant[i]) begin
          r_cnt[i] <= i_req_len[i*LEN_W +: LEN_W];
          r_dst[i] <= i_req_dst[i*NUM_PORTS +: NUM_PORTS];
        end else if (w_pop[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign o_pop     = w_pop;
  assign o_active  = r_active;
  assign o_mux_sel = r_sel;

endmodule

// File: tb/tb_switch_sched.sv
// Directed bench for switch_sched: allocation, round-robin, multicast, backpressure, reset abort.
module tb_switch_sched;
  import switch_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_dst = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  out_ready = 4'hF;
  logic [3:0]  pop, active, busy;
  logic [7:0]  mux_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_dst   (req_dst),
    .i_req_len   (req_len),
    .i_out_ready (out_ready),
    .o_pop       (pop),
    .o_mux_sel   (mux_sel),
    .o_active    (active),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] dst, input logic [3:0] len);
    req_dst[i*4 +: 4] = dst;
    req_len[i*4 +: 4] = len;
  endtask

  function automatic logic [1:0] sel_of(input int o);
    return mux_sel[o*2 +: 2];
  endfunction

  task automatic do_reset;
    rst_n     = 1'b0;
    req_dst   = '0;
    out_ready = 4'hF;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  logic [6:0] rdy_pat;
  int         pop_cnt;

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(mux_sel), 32'h0);
    rst_n = 1'b1;

    // Unicast in0 -> out1, 4 beats
    set_req(0, 4'b0010, 4'd3);
    tick;
    set_req(0, 4'b0000, 4'd0);
    chk("t1_active", 32'(active), 32'h2);
    chk("t1_sel1", 32'(sel_of(1)), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_pop%0d", k), 32'(pop), 32'h1);
      tick;
    end
    chk("t1_rel_active", 32'(active), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'h0);
    chk("t1_rel_pop", 32'(pop), 32'h0);

    // Disjoint masks granted in the same cycle
    set_req(0, 4'b0001, 4'd0);
    set_req(1, 4'b0010, 4'd0);
    tick;
    req_dst = '0;
    chk("t2_active", 32'(active), 32'h3);
    chk("t2_pop", 32'(pop), 32'h3);
    chk("t2_busy", 32'(busy), 32'h3);
    tick;
    chk("t2_rel", 32'(active), 32'h0);

    // Round-robin contention on out3 from rr_ptr=0
    do_reset;
    set_req(0, 4'b1000, 4'd0);
    set_req(2, 4'b1000, 4'd0);
    tick;
    set_req(0, 4'b0000, 4'd0);
    chk("t3_first_sel", 32'(sel_of(3)), 32'h0);
    chk("t3_first_pop", 32'(pop), 32'h1);
    tick;
    chk("t3_gap", 32'(active), 32'h0);
    tick;
    chk("t3_second_sel", 32'(sel_of(3)), 32'h2);
    chk("t3_second_pop", 32'(pop), 32'h4);
    // rr_ptr must now be 3: in3 beats in0 for out0
    set_req(2, 4'b0000, 4'd0);
    set_req(0, 4'b0001, 4'd0);
    set_req(3, 4'b0001, 4'd0);
    tick;
    req_dst = '0;
    chk("t3_ptr_sel0", 32'(sel_of(0)), 32'h3);
    chk("t3_ptr_active", 32'(active), 32'h1);
    chk("t3_ptr_busy", 32'(busy), 32'h8);
    tick;
    tick;

    // Multicast in1 (out0+out2) waits for in3 to release out2
    set_req(3, 4'b0100, 4'd5);
    tick;
    set_req(3, 4'b0000, 4'd0);
    set_req(1, 4'b0101, 4'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_wait_active%0d", k), 32'(active), 32'h4);
      chk($sformatf("t4_wait_pop%0d", k), 32'(pop), 32'h8);
      tick;
    end
    chk("t4_gap", 32'(active), 32'h0);
    tick;
    set_req(1, 4'b0000, 4'd0);
    chk("t4_mc_active", 32'(active), 32'h5);
    chk("t4_mc_sel0", 32'(sel_of(0)), 32'h1);
    chk("t4_mc_sel2", 32'(sel_of(2)), 32'h1);
    chk("t4_mc_pop1", 32'(pop), 32'h2);
    out_ready = 4'b1011;
    #1;
    chk("t4_mc_stall", 32'(pop), 32'h0);
    out_ready = 4'hF;
    tick;
    chk("t4_mc_pop2", 32'(pop), 32'h2);
    tick;
    chk("t4_mc_rel", 32'(active), 32'h0);

    // Backpressure on out1 for three cycles mid-burst
    set_req(0, 4'b0010, 4'd3);
    tick;
    set_req(0, 4'b0000, 4'd0);
    rdy_pat = 7'b1110001;
    pop_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = rdy_pat[k] ? 4'hF : 4'b1101;
      #1;
      chk($sformatf("t5_pop%0d", k), 32'(pop[0]), 32'(rdy_pat[k]));
      chk($sformatf("t5_sel%0d", k), 32'(sel_of(1)), 32'h0);
      chk($sformatf("t5_active%0d", k), 32'(active), 32'h2);
      if (pop[0]) pop_cnt++;
      tick;
    end
    out_ready = 4'hF;
    chk("t5_total_pops", 32'(pop_cnt), 32'd4);
    chk("t5_rel", 32'(active), 32'h0);

    // Asynchronous reset during the second beat of an 8-beat burst
    set_req(0, 4'b0010, 4'd7);
    tick;
    set_req(0, 4'b0000, 4'd0);
    chk("t6_beat1", 32'(pop), 32'h1);
    tick;
    chk("t6_beat2", 32'(pop), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_active", 32'(active), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_pop", 32'(pop), 32'h0);
    chk("t6_rst_sel", 32'(mux_sel), 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("t6_after_pop", 32'(pop), 32'h0);
    chk("t6_after_active", 32'(active), 32'h0);
    set_req(0, 4'b0010, 4'd0);
    tick;
    set_req(0, 4'b0000, 4'd0);
    chk("t6_fresh_pop", 32'(pop), 32'h1);
    chk("t6_fresh_active", 32'(active), 32'h2);
    tick;
    chk("t6_fresh_rel", 32'(active), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_sched.md
Name: switch_sched

Overview:
- Burst-level scheduler for the 4-port switch crossbar. Sits between the per-port input FIFOs and the output muxes.
- Allocates output ports to input ports for whole multi-beat packets, including multicast. Holds each connection until the last beat and honours per-output backpressure.
- Produces the per-input FIFO pop strobes and the per-output mux select/active controls.

Parameters:
- NUM_PORTS, 4, number of input and output ports.
- SEL_W, $clog2(NUM_PORTS), output mux select width.
- LEN_W, 4, burst length field width; the field encodes beats-1, so 1..16 beats.
- STARVE_LIMIT, 15, wait cycles before priority boost (used only with SCHED_STARVE_GUARD_EN).

Ports:
- clk  in  1  switch clock
- rst_n  in  1  asynchronous active-low reset
- req_dst  in  NUM_PORTS x NUM_PORTS  per-input one-hot/multicast destination mask; all-zero = no request
- req_len  in  NUM_PORTS x LEN_W  per-input burst length minus 1; sampled at allocation
- out_ready  in  NUM_PORTS  per-output sink can accept a beat this cycle
- pop  out  NUM_PORTS  per-input FIFO read strobe, one per transferred beat
- mux_sel  out  NUM_PORTS x SEL_W  per-output selected input index
- active  out  NUM_PORTS  per-output connection held (drives mux valid gating)
- busy  out  NUM_PORTS  per-input burst in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
  - All outputs reset to 0. RR pointer resets to 0. All input FSMs reset to IDLE. Beat counters reset to 0.
- Per-input FSM states:
  - IDLE: no allocation. Moves to XFER when allocated.
  - XFER: connection held.
- Allocation:
  - Evaluated combinationally each cycle over inputs in IDLE with non-zero req_dst.
  - Order is round-robin starting at rr_ptr.
  - An input wins only if every output in its mask is free (not active, not claimed by an earlier-ordered winner this cycle). Multicast is all-or-nothing.
  - Several inputs may win in one cycle if their masks are disjoint.
  - A winner registers at the clock edge:
    - active[o]=1 and mux_sel[o]=i for each o in its mask;
    - beat counter = req_len[i];
    - dst mask is latched;
    - busy[i]=1.
  - Request-to-active latency is 1 cycle.
- rr_ptr update: when at least one grant occurs, rr_ptr <= (first winner in RR order + 1) mod NUM_PORTS. Otherwise it is unchanged.
- Transfer:
  - In XFER, pop[i] is combinational and equals AND of out_ready over the latched mask. It is never asserted in IDLE.
  - Each pop decrements the counter.
  - A pop with counter == 0 is the last beat. At that edge the input returns to IDLE, busy[i]=0, and active clears on its outputs.
- Release and reuse: an output released at edge t may be re-allocated by the evaluation in cycle t (after the edge), so active is set again at t+1. Minimum gap is one idle cycle per output.
- Backpressure: out_ready low on any masked output stalls the whole burst, with no partial multicast beats. active and mux_sel are held during the stall.
- req_dst changes while an input is in XFER are ignored. Latched values govern the burst.
- Single-beat burst (req_len=0): one pop, then release.
- Reset mid-burst: immediate abort, all connections dropped, no pop after rst_n deasserts until a new allocation.

Optional Feature:
- SCHED_STARVE_GUARD_EN defined:
  - Each input has a wait counter, saturating at STARVE_LIMIT. It increments each cycle the input is IDLE with a request and not allocated, and clears on allocation.
  - Inputs at STARVE_LIMIT are evaluated before all others, in RR order among themselves.
  - A free output that a starved input needs is not given to any other input that cycle (reservation).
- Undefined: pure round-robin as above, no counters.

Decomposition:
- packet_pkg additions:
  - NUM_PORTS, SEL_W, LEN_W constants;
  - port_mask_t typedef (logic [NUM_PORTS-1:0]);
  - burst_len_t typedef;
  - sched_state_e enum {IDLE, XFER}.
- One sub-module, sched_rr_alloc: combinational masked round-robin allocator. Inputs are requests, masks, free vector and pointer. Outputs are the winner vector and next pointer. The FSMs, counters and registered outputs stay in switch_sched.

Test Plan:
- Reset then in0 req_dst=4'b0010, len=3, out_ready all 1 -> cycle+1: active[1]=1, mux_sel[1]=0; pop[0] high 4 consecutive cycles; active[1]=0 after the 4th.
- in0 and in2 both req 4'b1000 len=0, rr_ptr=0 -> in0 granted first; the next grant goes to in2; rr_ptr=3 after the second grant.
- in1 multicast 4'b0101 len=1 while in3 holds out2 (len=5) -> in1 waits until out2 is released, then active[0]=active[2]=1 the next cycle, 2 pops.
- in0→out1 len=3, out_ready[1] low for 3 cycles mid-burst -> pop[0] low exactly those cycles; total pops still 4; mux_sel[1] stable.
- rst_n low for 1 cycle during the 2nd beat of len=7 -> all outputs 0 asynchronously; no further pop until a fresh request is allocated.
- With SCHED_STARVE_GUARD_EN, STARVE_LIMIT=4: in0/in1 continuously re-requesting out0 len=0, in2 requests 4'b0011 -> in2 allocated within 6 cycles of its request.
